cplx_alu_seq: RTL and testbench

Multi-cycle sequencer that runs complex-number operations (addc.p, subc.p, mulc.p, conjc.p) as a series of real micro-ops on the shared single-cycle integer ALU. It sits beside the main execute stage. It borrows the ALU one cycle at a time through a request/grant pair, with the pipeline keeping priority. Selected-op codes use the same 6-bit ALU select encoding as the ALU control path.

---
 rtl/cplx_alu_seq_if.sv | 35 +++
 rtl/cplx_alu_seq.sv | 215 +++++++++++++++++++++
 tb/tb_cplx_alu_seq.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/cplx_alu_seq_if.sv
// Bundle between the complex-op sequencer, its launcher and the shared ALU.
// slave  : sequencer side (takes launch/operands and ALU result, drives status, results and ALU request)
// master : launcher/ALU side (the opposite directions)
interface cplx_alu_seq_if #(
    parameter int unsigned W = 32
);
    logic         start;
    logic [5:0]   op_sel;
    logic [W-1:0] a_re;
    logic [W-1:0] a_im;
    logic [W-1:0] b_re;
    logic [W-1:0] b_im;
    logic         busy;
    logic         done;
    logic         err;
    logic [W-1:0] res_re;
    logic [W-1:0] res_im;
    logic         alu_req;
    logic         alu_grant;
    logic [5:0]   alu_sel;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [W-1:0] alu_y;
    logic         alu_ovf;

    modport slave (
        input  start, op_sel, a_re, a_im, b_re, b_im, alu_grant, alu_y, alu_ovf,
        output busy, done, err, res_re, res_im, alu_req, alu_sel, alu_a, alu_b
    );

    modport master (
        output start, op_sel, a_re, a_im, b_re, b_im, alu_grant, alu_y, alu_ovf,
        input  busy, done, err, res_re, res_im, alu_req, alu_sel, alu_a, alu_b
    );
endinterface

// File: rtl/cplx_alu_seq.sv
// Complex-op sequencer: runs addc/subc/mulc/conjc as real micro-ops on a
// borrowed single-cycle ALU (request/grant, pipeline keeps priority).
// Ports: clk, rst_n (async, active-low), bus (cplx_alu_seq_if.slave):
//   start/op_sel/operands in, busy/done/err/res_* out, alu_* request port.
// Option: define CPLX_ALU_SEQ_OVF_EN to report ALU add/sub overflow via err.
module cplx_alu_seq #(
    parameter int unsigned W = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    cplx_alu_seq_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DONE} state_t;

    localparam int unsigned KW = 3;
    localparam logic [5:0] OP_ADDC  = 6'd22;
    localparam logic [5:0] OP_SUBC  = 6'd23;
    localparam logic [5:0] OP_MULC  = 6'd24;
    localparam logic [5:0] OP_CONJC = 6'd27;
    localparam logic [5:0] SEL_ADD  = 6'd4;
    localparam logic [5:0] SEL_SUB  = 6'd5;
    localparam logic [5:0] SEL_MUL  = 6'd8;
    // micro-op destinations: t0..t3, real result, imag result
    localparam logic [2:0] D_T0 = 3'd0;
    localparam logic [2:0] D_T1 = 3'd1;
    localparam logic [2:0] D_T2 = 3'd2;
    localparam logic [2:0] D_T3 = 3'd3;
    localparam logic [2:0] D_RE = 3'd4;
    localparam logic [2:0] D_IM = 3'd5;

    state_t          state;
    logic [KW-1:0]   k;
    logic [5:0]      op_q;
    logic [W-1:0]    ar, ai, br, bi;
    logic [W-1:0]    t_q [4];
    logic [W-1:0]    pre_re;

    logic            legal;
    logic            granted;
    logic [5:0]      first_sel;
    logic [W-1:0]    first_a, first_b;
    logic [2:0]      cur_dst;
    logic            cur_last;
    logic [5:0]      nxt_sel;
    logic [W-1:0]    nxt_a, nxt_b;

`ifdef CPLX_ALU_SEQ_OVF_EN
    logic            ovf_q;
    logic            ovf_hit;
    assign ovf_hit = granted & bus.alu_ovf & (bus.alu_sel != SEL_MUL);
`else
    logic            alu_ovf_unused;
    assign alu_ovf_unused = bus.alu_ovf;
`endif

    assign granted = bus.alu_req & bus.alu_grant;

    // Micro-op 0 of the op being launched, straight from the input operands.
    always_comb begin
        legal     = 1'b1;
        first_sel = SEL_ADD;
        first_a   = bus.a_re;
        first_b   = bus.b_re;
        case (bus.op_sel)
            OP_ADDC:  first_sel = SEL_ADD;
            OP_SUBC:  first_sel = SEL_SUB;
            OP_MULC:  first_sel = SEL_MUL;
            OP_CONJC: begin
                first_sel = SEL_SUB;
                first_a   = '0;
                first_b   = bus.a_im;
            end
            default:  legal = 1'b0;
        endcase
    end

    // Destination of micro-op k and the ALU fields of micro-op k+1.
    always_comb begin
        cur_dst  = D_T0;
        cur_last = 1'b0;
        nxt_sel  = '0;
        nxt_a    = '0;
        nxt_b    = '0;
        case (op_q)
            OP_ADDC, OP_SUBC: begin
                cur_dst  = (k == 3'd0) ? D_RE : D_IM;
                cur_last = (k == 3'd1);
                nxt_sel  = (op_q == OP_ADDC) ? SEL_ADD : SEL_SUB;
                nxt_a    = ai;
                nxt_b    = bi;
            end
            OP_MULC: begin
                cur_last = (k == 3'd5);
                case (k)
                    3'd0:    cur_dst = D_T0;
                    3'd1:    cur_dst = D_T1;
                    3'd2:    cur_dst = D_T2;
                    3'd3:    cur_dst = D_T3;
                    3'd4:    cur_dst = D_RE;
                    default: cur_dst = D_IM;
                endcase
                // every temporary read here was captured on an earlier grant
                case (k)
                    3'd0:    begin nxt_sel = SEL_MUL; nxt_a = ai;     nxt_b = bi;     end
                    3'd1:    begin nxt_sel = SEL_MUL; nxt_a = ar;     nxt_b = bi;     end
                    3'd2:    begin nxt_sel = SEL_MUL; nxt_a = ai;     nxt_b = br;     end
                    3'd3:    begin nxt_sel = SEL_SUB; nxt_a = t_q[0]; nxt_b = t_q[1]; end
                    default: begin nxt_sel = SEL_ADD; nxt_a = t_q[2]; nxt_b = t_q[3]; end
                endcase
            end
            OP_CONJC: begin
                cur_dst  = D_IM;
                cur_last = 1'b1;
            end
            default: ;
        endcase
    end

    // Sequencer state, captured temporaries and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            k           <= '0;
            op_q        <= '0;
            ar          <= '0;
            ai          <= '0;
            br          <= '0;
            bi          <= '0;
            t_q         <= '{default: '0};
            pre_re      <= '0;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
            bus.err     <= 1'b0;
            bus.res_re  <= '0;
            bus.res_im  <= '0;
            bus.alu_req <= 1'b0;
            bus.alu_sel <= '0;
            bus.alu_a   <= '0;
            bus.alu_b   <= '0;
`ifdef CPLX_ALU_SEQ_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        bus.busy <= 1'b1;
                        if (legal) begin
                            state       <= S_ISSUE;
                            op_q        <= bus.op_sel;
                            ar          <= bus.a_re;
                            ai          <= bus.a_im;
                            br          <= bus.b_re;
                            bi          <= bus.b_im;
                            k           <= '0;
                            bus.err     <= 1'b0;
                            bus.alu_req <= 1'b1;
                            bus.alu_sel <= first_sel;
                            bus.alu_a   <= first_a;
                            bus.alu_b   <= first_b;
`ifdef CPLX_ALU_SEQ_OVF_EN
                            ovf_q       <= 1'b0;
`endif
                        end else begin
                            state    <= S_DONE;
                            bus.done <= 1'b1;
                            bus.err  <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    if (granted) begin
                        case (cur_dst)
                            D_T0:    t_q[0] <= bus.alu_y;
                            D_T1:    t_q[1] <= bus.alu_y;
                            D_T2:    t_q[2] <= bus.alu_y;
                            D_T3:    t_q[3] <= bus.alu_y;
                            D_RE:    pre_re <= bus.alu_y;
                            default: ;
                        endcase
                        if (cur_last) begin
                            // every op's final micro-op writes the imaginary part
                            state       <= S_DONE;
                            bus.done    <= 1'b1;
                            bus.res_im  <= bus.alu_y;
                            bus.res_re  <= (op_q == OP_CONJC) ? ar : pre_re;
                            bus.alu_req <= 1'b0;
                            bus.alu_sel <= '0;
                            bus.alu_a   <= '0;
                            bus.alu_b   <= '0;
`ifdef CPLX_ALU_SEQ_OVF_EN
                            bus.err     <= ovf_q | ovf_hit;
`endif
                        end else begin
                            k           <= KW'(k + 3'd1);
                            bus.alu_sel <= nxt_sel;
                            bus.alu_a   <= nxt_a;
                            bus.alu_b   <= nxt_b;
`ifdef CPLX_ALU_SEQ_OVF_EN
                            ovf_q       <= ovf_q | ovf_hit;
`endif
                        end
                    end
                end
                S_DONE: begin
                    state    <= S_IDLE;
                    bus.done <= 1'b0;
                    bus.busy <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cplx_alu_seq.sv
// Randomised self-checking bench for cplx_alu_seq against a complex-arithmetic model.
module tb_cplx_alu_seq;
    localparam int unsigned W = 32;
`ifdef CPLX_ALU_SEQ_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    cplx_alu_seq_if #(.W(W)) bus ();
    cplx_alu_seq #(.W(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    // shared single-cycle integer ALU
    always_comb begin
        case (bus.alu_sel)
            6'd4:    bus.alu_y = bus.alu_a + bus.alu_b;
            6'd5:    bus.alu_y = bus.alu_a - bus.alu_b;
            6'd8:    bus.alu_y = bus.alu_a * bus.alu_b;
            default: bus.alu_y = '0;
        endcase
    end

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_re = '0;
    logic [W-1:0] exp_im = '0;

    // grant_mode: 0 tied high, 1 random, 2 low in cycles 2..4 after acceptance
    task automatic run_op(input string name, input logic [5:0] op,
                          input logic [W-1:0] ar, input logic [W-1:0] ai,
                          input logic [W-1:0] br, input logic [W-1:0] bi,
                          input int grant_mode, input bit pulse_busy,
                          input bit force_ovf, input bit ovf_noise);
        int base, nuops, cyc, stalls, reqs, ngrant;
        bit legal, g, held, exp_err;
        logic [5:0] h_sel;
        logic [W-1:0] h_a, h_b;
        legal = 1'b1;
        case (op)
            6'd22: begin base = 3; nuops = 2; exp_re = ar + br; exp_im = ai + bi; end
            6'd23: begin base = 3; nuops = 2; exp_re = ar - br; exp_im = ai - bi; end
            6'd24: begin base = 7; nuops = 6; exp_re = ar * br - ai * bi; exp_im = ar * bi + ai * br; end
            6'd27: begin base = 2; nuops = 1; exp_re = ar; exp_im = '0 - ai; end
            default: begin base = 1; nuops = 0; legal = 1'b0; end
        endcase
        exp_err = !legal || (OVF_EN && (force_ovf || ovf_noise));

        bus.start = 1'b1; bus.op_sel = op;
        bus.a_re = ar; bus.a_im = ai; bus.b_re = br; bus.b_im = bi;
        @(posedge clk); #1;
        bus.start = 1'b0;
        cyc = 1; stalls = 0; reqs = 0; ngrant = 0; held = 1'b0;
        h_sel = '0; h_a = '0; h_b = '0;
        while (1'b1) begin
            if (held) begin
                checks++;
                if (bus.alu_sel !== h_sel || bus.alu_a !== h_a || bus.alu_b !== h_b) begin
                    errors++;
                    $display("FAIL %s stall_hold cyc %0d got %0d/%h/%h exp %0d/%h/%h",
                             name, cyc, bus.alu_sel, bus.alu_a, bus.alu_b, h_sel, h_a, h_b);
                end
            end
            if (bus.done === 1'b1) break;
            checks++;
            if (cyc > 60 || bus.busy !== 1'b1) begin
                errors++;
                $display("FAIL %s progress cyc %0d busy %b done %b exp done within %0d",
                         name, cyc, bus.busy, bus.done, base + stalls);
                break;
            end
            case (grant_mode)
                0:       g = 1'b1;
                2:       g = !(cyc >= 2 && cyc <= 4);
                default: g = ($urandom_range(0, 3) != 0);
            endcase
            bus.alu_grant = g;
            bus.alu_ovf = ovf_noise || (force_ovf && bus.alu_req && g && ngrant == 0);
            if (bus.alu_req === 1'b1) begin
                reqs++;
                if (g) ngrant++; else stalls++;
            end
            held = (bus.alu_req === 1'b1) && !g;
            h_sel = bus.alu_sel; h_a = bus.alu_a; h_b = bus.alu_b;
            if (pulse_busy) begin
                bus.start = 1'b1;
                bus.op_sel = 6'd22;
            end
            @(posedge clk); #1;
            cyc++;
        end
        bus.alu_ovf = 1'b0;

        checks++;
        if (cyc !== base + stalls) begin
            errors++;
            $display("FAIL %s done_cycle got N+%0d exp N+%0d", name, cyc, base + stalls);
        end
        checks++;
        if (reqs !== nuops + stalls) begin
            errors++;
            $display("FAIL %s req_cycles got %0d exp %0d", name, reqs, nuops + stalls);
        end
        checks++;
        if (bus.res_re !== exp_re || bus.res_im !== exp_im) begin
            errors++;
            $display("FAIL %s result got (%h,%h) exp (%h,%h)", name, bus.res_re, bus.res_im, exp_re, exp_im);
        end
        checks++;
        if (bus.err !== exp_err) begin
            errors++;
            $display("FAIL %s err got %b exp %b", name, bus.err, exp_err);
        end
        checks++;
        if (bus.busy !== 1'b1 || bus.alu_req !== 1'b0 || bus.alu_sel !== 6'd0 ||
            bus.alu_a !== '0 || bus.alu_b !== '0) begin
            errors++;
            $display("FAIL %s done_cycle_outputs got busy %b req %b sel %0d a %h b %h exp 1 0 0 0 0",
                     name, bus.busy, bus.alu_req, bus.alu_sel, bus.alu_a, bus.alu_b);
        end
        @(posedge clk); #1;
        bus.start = 1'b0;
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.err !== exp_err ||
            bus.res_re !== exp_re || bus.res_im !== exp_im) begin
            errors++;
            $display("FAIL %s after_done got done %b busy %b err %b res (%h,%h) exp 0 0 %b (%h,%h)",
                     name, bus.done, bus.busy, bus.err, bus.res_re, bus.res_im, exp_err, exp_re, exp_im);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.start = 1'b0; bus.op_sel = '0;
        bus.a_re = '0; bus.a_im = '0; bus.b_re = '0; bus.b_im = '0;
        bus.alu_grant = 1'b0; bus.alu_ovf = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.err, bus.alu_req} !== 4'b0 || bus.res_re !== '0 || bus.res_im !== '0 ||
            bus.alu_sel !== 6'd0 || bus.alu_a !== '0 || bus.alu_b !== '0) begin
            errors++;
            $display("FAIL reset_state got busy %b done %b err %b req %b res (%h,%h) sel %0d exp all zero",
                     bus.busy, bus.done, bus.err, bus.alu_req, bus.res_re, bus.res_im, bus.alu_sel);
        end
        rst_n = 1'b1;
        exp_re = '0; exp_im = '0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        run_op("addc_basic", 6'd22, 32'd3, 32'd4, 32'd1, -32'sd2, 0, 1'b0, 1'b0, 1'b0);
        run_op("mulc_basic", 6'd24, 32'd2, 32'd3, 32'd4, 32'd5, 0, 1'b0, 1'b0, 1'b0);
        run_op("mulc_stall", 6'd24, 32'd2, 32'd3, 32'd4, 32'd5, 2, 1'b0, 1'b0, 1'b0);
        run_op("illegal_25", 6'd25, 32'd9, 32'd9, 32'd9, 32'd9, 0, 1'b0, 1'b0, 1'b0);
        run_op("conjc_busy", 6'd27, 32'd5, 32'd7, 32'd0, 32'd0, 0, 1'b1, 1'b0, 1'b0);
        run_op("subc_basic", 6'd23, 32'd10, -32'sd1, 32'd20, 32'd6, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_ovf();
        run_op("addc_ovf", 6'd22, 32'h7FFF_FFFF, 32'd0, 32'd1, 32'd0, 0, 1'b0, 1'b1, 1'b0);
        run_op("mulc_ovf_noise", 6'd24, 32'h1234_5678, 32'h8000_0001, 32'hFFFF_FFFF, 32'd7, 1, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid();
        bus.start = 1'b1; bus.op_sel = 6'd24;
        bus.a_re = 32'd6; bus.a_im = 32'd1; bus.b_re = 32'd2; bus.b_im = 32'd3;
        bus.alu_grant = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.err, bus.alu_req} !== 4'b0 || bus.res_re !== '0 || bus.res_im !== '0 ||
            bus.alu_sel !== 6'd0 || bus.alu_a !== '0 || bus.alu_b !== '0) begin
            errors++;
            $display("FAIL reset_mid got busy %b done %b err %b req %b res (%h,%h) sel %0d exp all zero",
                     bus.busy, bus.done, bus.err, bus.alu_req, bus.res_re, bus.res_im, bus.alu_sel);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            checks++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_no_done cyc %0d got done %b busy %b exp 0 0", i, bus.done, bus.busy);
            end
        end
        exp_re = '0; exp_im = '0;
    endtask

    task automatic test_random();
        logic [5:0] op;
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 4))
                0: op = 6'd22;
                1: op = 6'd23;
                2: op = 6'd24;
                3: op = 6'd27;
                default: begin
                    op = 6'($urandom_range(0, 63));
                    while (op == 6'd22 || op == 6'd23 || op == 6'd24 || op == 6'd27)
                        op = 6'($urandom_range(0, 63));
                end
            endcase
            run_op("random", op, $urandom, $urandom, $urandom, $urandom, 1,
                   1'b0, 1'b0, 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ovf();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
